// File: rtl/frame_stage_sequencer.sv
// rtl/frame_stage_sequencer.sv - sequences enabled producer stages through start/done handshakes, then one reader swap
module frame_stage_sequencer #(
    parameter int N_STAGE        = 2,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int FC_W           = 16,
    localparam int IDX_W         = (N_STAGE > 1) ? $clog2(N_STAGE) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               single,
    input  logic [N_STAGE-1:0] stage_en,
    input  logic               clear_err,
    output logic [N_STAGE-1:0] start,
    input  logic [N_STAGE-1:0] start_ack,
    input  logic [N_STAGE-1:0] done,
    output logic [N_STAGE-1:0] done_ack,
    output logic               swap,
    input  logic               swap_ack,
    output logic               busy,
    output logic [IDX_W-1:0]   stage_idx,
    output logic [FC_W-1:0]    frame_count,
    output logic [N_STAGE:0]   timeout_err
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, DONE_REL, SWAP_REQ, SWAP_REL} state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx_d, first_idx, next_idx;
    logic               next_found, leave;
    logic [N_STAGE-1:0] en_q, en_d, start_d, done_ack_d;
    logic               swap_d;
    logic [FC_W-1:0]    fc_d;
    logic [N_STAGE:0]   err_d;
    logic [TW-1:0]      timer, timer_d;

    // first_idx picks from the live mask (frame start); next_idx walks the latched mask
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = N_STAGE - 1; i >= 0; i--) begin
            if (stage_en[i]) first_idx = IDX_W'(i);
            if (en_q[i] && (i > int'(stage_idx))) begin
                next_idx   = IDX_W'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state;
        idx_d      = stage_idx;
        en_d       = en_q;
        start_d    = start;
        done_ack_d = done_ack;
        swap_d     = swap;
        fc_d       = frame_count;
        err_d      = clear_err ? '0 : timeout_err;
        leave      = 1'b0;
        case (state)
            IDLE: begin
                if ((run || single) && (timeout_err == '0)) begin
                    en_d  = stage_en;
                    leave = 1'b1;
                    if (stage_en == '0) begin
                        idx_d   = '0;
                        state_d = SWAP_REQ;
                    end else begin
                        idx_d   = first_idx;
                        state_d = START;
                    end
                end
            end
            START: begin
                // request only rises against a low ack, so a stale ack is never taken
                if (start[stage_idx] && start_ack[stage_idx]) begin
                    start_d[stage_idx] = 1'b0;
                    state_d            = WAIT_DONE;
                    leave              = 1'b1;
                end else if (!start_ack[stage_idx]) begin
                    start_d[stage_idx] = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (done[stage_idx]) begin
                    done_ack_d[stage_idx] = 1'b1;
                    state_d               = DONE_REL;
                    leave                 = 1'b1;
                end
            end
            DONE_REL: begin
                if (!done[stage_idx]) begin
                    done_ack_d[stage_idx] = 1'b0;
                    leave                 = 1'b1;
                    if (next_found) begin
                        idx_d   = next_idx;
                        state_d = START;
                    end else begin
                        state_d = SWAP_REQ;
                    end
                end
            end
            SWAP_REQ: begin
                if (swap && swap_ack) begin
                    swap_d  = 1'b0;
                    state_d = SWAP_REL;
                    leave   = 1'b1;
                end else begin
                    swap_d = 1'b1;
                end
            end
            SWAP_REL: begin
                if (!swap_ack) begin
                    fc_d    = frame_count + 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                    leave   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((TIMEOUT_CYCLES == 0) || (state == IDLE) || leave) timer_d = '0;
        else                                                    timer_d = timer + 1'b1;

        // abort overrides everything decided above, including a coincident clear_err
        if ((TIMEOUT_CYCLES > 0) && (state != IDLE) && !leave && (timer == T_LAST)) begin
            if ((state == SWAP_REQ) || (state == SWAP_REL)) err_d[N_STAGE]   = 1'b1;
            else                                            err_d[stage_idx] = 1'b1;
            state_d    = IDLE;
            idx_d      = '0;
            start_d    = '0;
            done_ack_d = '0;
            swap_d     = 1'b0;
            timer_d    = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            stage_idx   <= '0;
            en_q        <= '0;
            start       <= '0;
            done_ack    <= '0;
            swap        <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            timeout_err <= '0;
            timer       <= '0;
        end else begin
            state       <= state_d;
            stage_idx   <= idx_d;
            en_q        <= en_d;
            start       <= start_d;
            done_ack    <= done_ack_d;
            swap        <= swap_d;
            busy        <= (state_d != IDLE);
            frame_count <= fc_d;
            timeout_err <= err_d;
            timer       <= timer_d;
        end
    end
endmodule

// File: doc/frame_stage_sequencer.md
Name: frame_stage_sequencer

Overview:
- Parametrised successor to the fixed two-producer swap controller.
- Sequences N_STAGE frame producers (background writer, overlay, future feature-detect passes) in index order through per-stage start and done four-phase handshakes, then issues one swap handshake to the image buffer reader.
- Adds a per-frame stage-enable mask, run/single-shot modes, a frame counter and per-handshake timeout detection.
- Single clock domain (clk_10M in the top level).

Parameters:
- N_STAGE, 2, number of producer stages; 1..16.
- TIMEOUT_CYCLES, 0, cycles allowed in any wait state before abort; 0 disables timeouts.
- FC_W, 16, frame_count width.
- IDX_W (localparam), max(1,clog2(N_STAGE)), stage index width.

Ports:
- clock  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  level: while high, start a new frame whenever IDLE.
- single  in  1  one-cycle pulse: start exactly one frame if IDLE; ignored otherwise.
- stage_en  in  N_STAGE  stage mask, sampled at frame start.
- clear_err  in  1  one-cycle pulse: clears timeout_err.
- start  out  N_STAGE  per-stage start request.
- start_ack  in  N_STAGE  per-stage start acknowledge.
- done  in  N_STAGE  per-stage done request from producer.
- done_ack  out  N_STAGE  per-stage done acknowledge.
- swap  out  1  buffer swap request to reader.
- swap_ack  in  1  swap acknowledge from reader.
- busy  out  1  high in any state other than IDLE.
- stage_idx  out  IDX_W  index of the active stage; 0 in IDLE.
- frame_count  out  FC_W  completed-frame counter; wraps modulo 2^FC_W.
- timeout_err  out  N_STAGE+1  sticky timeout flags; bit i = stage i, MSB = swap.

Behaviour:
- Reset (async): all outputs 0, state IDLE, en_q 0, timer 0. Reset mid-handshake drops every request and ack in the same instant; there is no resume.
- All outputs are registered. At most one bit of start, done_ack and swap is high at any time.
- States: IDLE, START, WAIT_DONE, DONE_REL, SWAP_REQ, SWAP_REL.
- IDLE:
  - If (run | single) and timeout_err==0: latch en_q<=stage_en, set idx to the lowest enabled stage, go START.
  - If en_q would be 0 (no stage enabled), go directly to SWAP_REQ.
  - run and single high together start one frame. single while busy is dropped, not queued.
- START:
  - Assert start[idx] only once start_ack[idx] is sampled low, so a stale ack is never accepted.
  - When start_ack[idx] is sampled high: start[idx]<=0, go WAIT_DONE.
  - Latency: start[idx] rises 1 cycle after the IDLE decision when start_ack is already low.
- WAIT_DONE: on done[idx] high: done_ack[idx]<=1, go DONE_REL.
- DONE_REL:
  - On done[idx] low: done_ack[idx]<=0.
  - idx <= next higher enabled index in en_q, go START; if none remains, go SWAP_REQ.
- SWAP_REQ: swap<=1; on swap_ack high: swap<=0, go SWAP_REL.
- SWAP_REL: on swap_ack low: frame_count<=frame_count+1 (wrap), go IDLE. busy falls that same edge.
- run deasserted mid-frame: the current frame completes; no new frame starts.
- stage_en changes mid-frame have no effect until the next frame start.
- Inputs of non-active stages are ignored entirely.
- Timeout (TIMEOUT_CYCLES>0):
  - The timer clears on every state entry and increments in START, WAIT_DONE, DONE_REL, SWAP_REQ and SWAP_REL.
  - When timer==TIMEOUT_CYCLES-1 and the exit condition is not met, next edge: set timeout_err[idx] (or the MSB in swap states), drive all requests/acks 0, go IDLE. frame_count is not incremented.
- While timeout_err!=0, no frame starts.
- clear_err zeroes timeout_err. If clear_err coincides with a new timeout, the new error wins.
- With TIMEOUT_CYCLES=0 the timer is held at 0 and timeout_err stays 0.

Test Plan:
- N_STAGE=2, stage_en=2'b11, single pulse, producers ack after 3 cycles -> start[0] then start[1] handshakes in order, then swap; frame_count 0->1; busy low after SWAP_REL.
- run held high, 3 frames -> frame_count=3; there is no cycle where start, done_ack and swap overlap; start[0] rises 1 cycle after each busy fall-and-restart decision.
- stage_en=2'b10 -> start[0] never asserts, stage_idx=1 throughout; stage_en=2'b00 -> swap asserts 1 cycle after single, frame_count increments.
- TIMEOUT_CYCLES=16, stage 1 never raises done -> after 16 WAIT_DONE cycles timeout_err=3'b010, all outputs 0, run ignored; clear_err -> next frame starts.
- FC_W=4, run for 17 frames -> frame_count=1 (wrap at 16).
- Assert reset while done_ack[0]=1 -> done_ack, busy and stage_idx go 0 without a clock edge; after release with run=1, start[0] reasserts once start_ack[0] is low.
